div_clk_monitor: RTL and testbench

DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

---
 rtl/div_clk_monitor_pkg.sv | 24 ++
 rtl/div_clk_monitor_sync_edge.sv | 29 ++
 rtl/div_clk_monitor.sv | 148 ++++++++++++++
 tb/tb_div_clk_monitor.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_clk_monitor_pkg.sv
// Shared types and constants for the divided-clock monitor.
// FSM encoding, timeout multiplier and the period tolerance check.
package div_clk_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // A period longer than this many expected periods means the clock stopped
    localparam int TIMEOUT_MULT = 4;

    function automatic logic period_good(
        input int p,
        input int exp_p,
        input int tol
    );
        int d;
        d = (p >= exp_p) ? p - exp_p : exp_p - p;
        return d <= tol;
    endfunction

endpackage

// File: rtl/div_clk_monitor_sync_edge.sv
// Two-flop synchronizer plus history flop for the divided clock.
// rise is combinational from s2/s3 and marks one detected rising edge.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s2,
    output logic rise
);

    logic s1;
    logic s3;

    // Synchronizer chain with one extra stage of history
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock and tracks lock.
// Loss of lock is reported as a strobe and a saturating error count.
module div_clk_monitor
    import div_clk_monitor_pkg::*;
#(
    parameter int EXP_PERIOD = 3,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             clr_err,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(TIMEOUT_MULT * EXP_PERIOD);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);

    logic             s2;
    logic             rise;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_run;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] good_nx;
    state_t           state;
    state_t           state_nx;
    logic             meas_good;
    logic             timeout;
    logic             err_nx;

    sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (div_in),
        .s2   (s2),
        .rise (rise)
    );

    assign meas_good = period_good(32'(per_cnt), EXP_PERIOD, TOL);
    assign timeout   = per_cnt >= TIMEOUT;
    assign locked    = state == LOCKED;

    // Rise-to-rise and high-time counters, latched on every rise
    always_ff @(posedge clk) begin
        if (!rst) begin
            per_cnt    <= '0;
            hi_run     <= '0;
            period     <= '0;
            high_cnt   <= '0;
            rise_pulse <= 1'b0;
        end else begin
            rise_pulse <= rise;
            if (rise) begin
                period   <= per_cnt;
                high_cnt <= hi_run;
                per_cnt  <= CNT_W'(1);
                hi_run   <= CNT_W'(1);
            end else begin
                if (per_cnt != CNT_MAX) begin
                    per_cnt <= per_cnt + 1'b1;
                end
                if (s2 && hi_run != CNT_MAX) begin
                    hi_run <= hi_run + 1'b1;
                end
            end
        end
    end

    // FSM state, good-period counter and error strobe registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            good_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
            err      <= err_nx;
        end
    end

    // Next-state logic; rise takes priority over timeout
    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = ACQUIRE;
                    good_nx  = '0;
                end
            end
            ACQUIRE: begin
                if (rise) begin
                    if (meas_good) begin
                        good_nx = good_cnt + 1'b1;
                        if (good_cnt >= LOCK_LAST) begin
                            state_nx = LOCKED;
                        end
                    end else begin
                        good_nx = '0;
                    end
                end else if (timeout) begin
                    state_nx = IDLE;
                    good_nx  = '0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (!meas_good) begin
                        state_nx = ACQUIRE;
                        good_nx  = '0;
                        err_nx   = 1'b1;
                    end
                end else if (timeout) begin
                    state_nx = IDLE;
                    good_nx  = '0;
                    err_nx   = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                good_nx  = '0;
            end
        endcase
    end

    // Saturating error counter; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt <= 8'd0;
        end else if (clr_err) begin
            err_cnt <= 8'd0;
        end else if (err_nx && err_cnt != 8'hff) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Testbench for div_clk_monitor: TOL=0 and TOL=1 instances share stimulus.
// A rise-time based reference model predicts every output each cycle.
module tb_div_clk_monitor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic div_in = 1'b0;
    logic clr_err = 1'b0;
    logic rp0, lk0, er0, rp1, lk1, er1;
    logic [7:0] per0, hi0, ec0, per1, hi1, ec1;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_clk_monitor #(.EXP_PERIOD(3), .TOL(0), .LOCK_CNT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .div_in(div_in), .clr_err(clr_err),
        .rise_pulse(rp0), .period(per0), .high_cnt(hi0),
        .locked(lk0), .err(er0), .err_cnt(ec0)
    );

    div_clk_monitor #(.EXP_PERIOD(3), .TOL(1), .LOCK_CNT(4), .CNT_W(8)) dut_t (
        .clk(clk), .rst(rst), .div_in(div_in), .clr_err(clr_err),
        .rise_pulse(rp1), .period(per1), .high_cnt(hi1),
        .locked(lk1), .err(er1), .err_cnt(ec1)
    );

    // Model: st 0=idle 1=acquire 2=locked; L = edge of last rise; hs = first
    // sample index belonging to the current high-time window
    typedef struct {
        int st; int good; int ecnt; int per; int hi;
        int err; int rp; int L; int hs;
    } m_t;

    m_t m0, m1;
    bit samp [0:32767];
    int n = 4;

    function automatic m_t mstep(input m_t a, input int tol, input int e,
                                 input logic rs, input logic clr);
        m_t b;
        int p, h;
        bit rise, good;
        b = a;
        if (!rs) begin
            b = '{default: 0};
            b.L = e + 1;
            b.hs = e - 2;
            return b;
        end
        rise = samp[e-2] && !samp[e-3];
        b.rp = int'(rise);
        b.err = 0;
        if (rise) begin
            p = e - a.L;
            if (p > 255) p = 255;
            h = 0;
            for (int k = a.hs; k <= e - 3; k++) h += int'(samp[k]);
            if (h > 255) h = 255;
            b.per = p;
            b.hi = h;
            good = (((p > 3) ? p - 3 : 3 - p) <= tol);
            if (a.st == 0) begin
                b.st = 1; b.good = 0;
            end else if (a.st == 1) begin
                if (good) begin
                    b.good = a.good + 1;
                    if (b.good >= 4) b.st = 2;
                end else b.good = 0;
            end else if (!good) begin
                b.st = 1; b.good = 0; b.err = 1;
            end
            b.L = e;
            b.hs = e - 2;
        end else if (a.st != 0 && e - a.L >= 12) begin
            b.err = (a.st == 2) ? 1 : 0;
            b.st = 0;
            b.good = 0;
        end
        if (clr) b.ecnt = 0;
        else if (b.err != 0 && b.ecnt < 255) b.ecnt = b.ecnt + 1;
        return b;
    endfunction

    always @(posedge clk) begin
        samp[n] <= rst ? div_in : 1'b0;
        if (!rst) begin
            samp[n-1] <= 1'b0;
            samp[n-2] <= 1'b0;
        end
        m0 <= mstep(m0, 0, n, rst, clr_err);
        m1 <= mstep(m1, 1, n, rst, clr_err);
        n <= n + 1;
    end

    function automatic logic [26:0] expv(input m_t a);
        return {1'(a.rp), 8'(a.per), 8'(a.hi), a.st == 2, 1'(a.err), 8'(a.ecnt)};
    endfunction

    function automatic logic [26:0] obs0();
        return {rp0, per0, hi0, lk0, er0, ec0};
    endfunction

    function automatic logic [26:0] obs1();
        return {rp1, per1, hi1, lk1, er1, ec1};
    endfunction

    task automatic step(input logic d, input logic c, input logic r);
        div_in = d;
        clr_err = c;
        rst = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (obs0() !== '0 || obs1() !== '0) begin
            fails++;
            $display("FAIL reset_state got=%h/%h exp=0", obs0(), obs1());
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (obs0() !== expv(m0) || obs1() !== expv(m1)) begin
                fails++;
                $display("FAIL reset_idle got=%h/%h exp=%h/%h",
                         obs0(), obs1(), expv(m0), expv(m1));
            end
        end
    endtask

    task automatic test_lock();
        int hk = 1;
        for (int k = 0; k < 7; k++) begin
            for (int c = 0; c < 3; c++) begin
                if (c == 0) hk = int'($urandom_range(1, 2));
                step(c < hk, 1'b0, 1'b1);
                checks++;
                if (obs0() !== expv(m0) || obs1() !== expv(m1)) begin
                    fails++;
                    $display("FAIL lock got=%h/%h exp=%h/%h",
                             obs0(), obs1(), expv(m0), expv(m1));
                end
                if (c == 2 && (k == 3 || k == 4)) begin
                    checks++;
                    if (lk0 !== (k == 4)) begin
                        fails++;
                        $display("FAIL lock_after_5 rise=%0d got=%b", k + 1, lk0);
                    end
                end
            end
        end
        checks++;
        if (per0 !== 8'd3 || !(hi0 == 8'd1 || hi0 == 8'd2)) begin
            fails++;
            $display("FAIL div3_measure got per=%0d hi=%0d exp per=3 hi=1..2", per0, hi0);
        end
    endtask

    task automatic test_stretch();
        int hk = int'($urandom_range(1, 4));
        for (int c = 0; c < 5; c++) begin
            step(c < hk, 1'b0, 1'b1);
            checks++;
            if (obs0() !== expv(m0) || obs1() !== expv(m1)) begin
                fails++;
                $display("FAIL stretch got=%h/%h exp=%h/%h",
                         obs0(), obs1(), expv(m0), expv(m1));
            end
        end
        for (int j = 0; j < 6; j++) begin
            for (int c = 0; c < 3; c++) begin
                step(c < 2, 1'b0, 1'b1);
                checks++;
                if (obs0() !== expv(m0) || obs1() !== expv(m1)) begin
                    fails++;
                    $display("FAIL relock got=%h/%h exp=%h/%h",
                             obs0(), obs1(), expv(m0), expv(m1));
                end
                if (j == 0 && c == 2) begin
                    checks++;
                    if (er0 !== 1'b1 || lk0 !== 1'b0 || ec0 !== 8'd1 || per0 !== 8'd5) begin
                        fails++;
                        $display("FAIL stretch_err got err=%b lk=%b cnt=%0d per=%0d exp 1 0 1 5",
                                 er0, lk0, ec0, per0);
                    end
                end
                if (j == 1 && c == 0) begin
                    checks++;
                    if (er0 !== 1'b0) begin
                        fails++;
                        $display("FAIL err_one_cycle got=%b exp=0", er0);
                    end
                end
                if (c == 2 && (j == 3 || j == 4)) begin
                    checks++;
                    if (lk0 !== (j == 4)) begin
                        fails++;
                        $display("FAIL relock_4 j=%0d got=%b", j, lk0);
                    end
                end
            end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (obs0() !== expv(m0) || obs1() !== expv(m1)) begin
                fails++;
                $display("FAIL timeout got=%h/%h exp=%h/%h",
                         obs0(), obs1(), expv(m0), expv(m1));
            end
            if (i == 10 || i == 11) begin
                checks++;
                if (lk0 !== (i == 10) || er0 !== (i == 11)) begin
                    fails++;
                    $display("FAIL timeout_edge i=%0d got lk=%b err=%b", i, lk0, er0);
                end
            end
        end
        checks++;
        if (per0 !== 8'd3 || ec0 !== 8'd2 || lk0 !== 1'b0) begin
            fails++;
            $display("FAIL timeout_hold got per=%0d cnt=%0d lk=%b exp 3 2 0", per0, ec0, lk0);
        end
    endtask

    task automatic test_err_sat();
        int p, hk;
        hk = 1;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 3; c++) begin
                step(c < 1, 1'b0, 1'b1);
                checks++;
                if (obs0() !== expv(m0) || obs1() !== expv(m1)) begin
                    fails++;
                    $display("FAIL sat_lock got=%h/%h exp=%h/%h",
                             obs0(), obs1(), expv(m0), expv(m1));
                end
            end
        end
        for (int r = 0; r < 256; r++) begin
            for (int q = 0; q < 5; q++) begin
                p = (q == 0) ? 5 : 3;
                for (int c = 0; c < p; c++) begin
                    if (c == 0) hk = int'($urandom_range(1, p - 1));
                    step(c < hk, 1'b0, 1'b1);
                    checks++;
                    if (obs0() !== expv(m0) || obs1() !== expv(m1)) begin
                        fails++;
                        $display("FAIL sat_loop r=%0d got=%h/%h exp=%h/%h",
                                 r, obs0(), obs1(), expv(m0), expv(m1));
                    end
                end
            end
        end
        checks++;
        if (ec0 !== 8'd255) begin
            fails++;
            $display("FAIL err_saturate got=%0d exp=255", ec0);
        end
        for (int c = 0; c < 5; c++) step(c < 2, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(c < 2, c == 2, 1'b1);
            checks++;
            if (obs0() !== expv(m0) || obs1() !== expv(m1)) begin
                fails++;
                $display("FAIL clr_model got=%h/%h exp=%h/%h",
                         obs0(), obs1(), expv(m0), expv(m1));
            end
            if (c == 2) begin
                checks++;
                if (er0 !== 1'b1 || ec0 !== 8'd0) begin
                    fails++;
                    $display("FAIL clr_wins got err=%b cnt=%0d exp 1 0", er0, ec0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) step(c < 2, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (obs0() !== '0 || obs1() !== '0) begin
            fails++;
            $display("FAIL reset_mid got=%h/%h exp=0", obs0(), obs1());
        end
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) begin
                step(c < 2, 1'b0, 1'b1);
                checks++;
                if (obs0() !== expv(m0) || obs1() !== expv(m1)) begin
                    fails++;
                    $display("FAIL reacquire got=%h/%h exp=%h/%h",
                             obs0(), obs1(), expv(m0), expv(m1));
                end
                if (c == 2 && (k == 3 || k == 4)) begin
                    checks++;
                    if (lk0 !== (k == 4)) begin
                        fails++;
                        $display("FAIL relock_fresh rise=%0d got=%b", k + 1, lk0);
                    end
                end
            end
        end
    endtask

    task automatic test_tol();
        int p, hk;
        hk = 1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            p = (k % 2 == 1) ? 4 : 2;
            for (int c = 0; c < p; c++) begin
                if (c == 0) hk = int'($urandom_range(1, p - 1));
                step(c < hk, 1'b0, 1'b1);
                checks++;
                if (obs0() !== expv(m0) || obs1() !== expv(m1)) begin
                    fails++;
                    $display("FAIL tol got=%h/%h exp=%h/%h",
                             obs0(), obs1(), expv(m0), expv(m1));
                end
            end
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (lk1 !== 1'b1 || ec1 !== 8'd0) begin
            fails++;
            $display("FAIL tol_lock got lk=%b cnt=%0d exp 1 0", lk1, ec1);
        end
    endtask

    task automatic test_random();
        int p, hk;
        for (int k = 0; k < 80; k++) begin
            p = ($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(2, 7));
            hk = int'($urandom_range(1, p - 1));
            for (int c = 0; c < p; c++) begin
                step(c < hk, $urandom_range(0, 15) == 0, 1'b1);
                checks++;
                if (obs0() !== expv(m0) || obs1() !== expv(m1)) begin
                    fails++;
                    $display("FAIL random k=%0d got=%h/%h exp=%h/%h",
                             k, obs0(), obs1(), expv(m0), expv(m1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_stretch();
        test_timeout();
        test_err_sat();
        test_reset_mid();
        test_tol();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
